// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: program counter, combinational imem addressing and a
// 2-entry {pc, instr} buffer feeding decode, with redirect and illegal-address halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  typedef enum logic [0:0] {StFetch, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
  logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;
  logic [1:0]  count_q, count_d;
  logic        fault_q, fault_d;
  logic [1:0]  wr_idx;
  logic        pop, legal, fetch, push;

  assign imem_addr   = {2'b00, pc_q[31:2]};
  assign out_valid   = (count_q != 2'd0);
  assign out_instr   = ins0_q;
  assign out_pc      = pc0_q;
  assign fetch_fault = fault_q;

  assign pop   = out_valid & out_ready;
  assign legal = (pc_q[1:0] == 2'b00) && ({2'b00, pc_q[31:2]} < MEM_WORDS);
  assign fetch = (state_q == StFetch) && ((count_q != 2'd2) || pop) && !redirect_valid;
  assign push  = fetch & legal;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc0_d   = pc0_q;
    ins0_d  = ins0_q;
    pc1_d   = pc1_q;
    ins1_d  = ins1_q;
    count_d = count_q;
    fault_d = fault_q;
    wr_idx  = count_q - {1'b0, pop};

    if (redirect_valid) begin
      // The popped head (if any) is already owned by decode; everything else is flushed.
      count_d = 2'd0;
      pc_d    = redirect_pc;
      state_d = StFetch;
      fault_d = 1'b0;
    end else begin
      if (pop) begin
        pc0_d  = pc1_q;
        ins0_d = ins1_q;
      end
      if (push) begin
        if (wr_idx == 2'd0) begin
          pc0_d  = pc_q;
          ins0_d = imem_instr;
        end else begin
          pc1_d  = pc_q;
          ins1_d = imem_instr;
        end
        pc_d = pc_q + 32'd4;
      end else if (fetch) begin
        state_d = StHalt;
        fault_d = 1'b1;
      end
      count_d = count_q - {1'b0, pop} + {1'b0, push};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      pc0_q   <= 32'h0;
      ins0_q  <= 32'h0;
      pc1_q   <= 32'h0;
      ins1_q  <= 32'h0;
      count_q <= 2'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc0_q   <= pc0_d;
      ins0_q  <= ins0_d;
      pc1_q   <= pc1_d;
      ins1_q  <= ins1_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random ready/redirect traffic,
// checked against a queue-based model of the fetch buffer.
module tb_instr_fetch_unit;

  localparam int unsigned MW = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc;
  logic        redirect_valid, out_valid, out_ready, fetch_fault;
  logic [31:0] s_addr, s_imem, s_instr, s_pc;
  logic        s_valid, s_fault;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 32'd1024) ? mem[imem_addr[9:0]] : 32'hDEAD_BEEF;
  assign s_imem     = (s_addr < 32'd1024) ? mem[s_addr[9:0]] : 32'hDEAD_BEEF;

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4)) u_small (
    .clk(clk), .reset(reset), .imem_addr(s_addr), .imem_instr(s_imem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(s_valid),
    .out_ready(out_ready), .out_instr(s_instr), .out_pc(s_pc), .fetch_fault(s_fault)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt, m_fault;
  int          tests = 0;
  int          fails = 0;

  function automatic bit m_legal(logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < MW);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h0;
    m_halt  = 1'b0;
    m_fault = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int  n    = mq.size();
    bit  take = (n > 0) && out_ready;
    bit  try_fetch;
    if (take) void'(mq.pop_front());
    if (redirect_valid) begin
      mq.delete();
      m_pc    = redirect_pc;
      m_halt  = 1'b0;
      m_fault = 1'b0;
    end else begin
      try_fetch = !m_halt && (n < 2 || take);
      if (try_fetch) begin
        if (m_legal(m_pc)) begin
          mq.push_back('{pc: m_pc, instr: mem[m_pc[11:2]]});
          m_pc = m_pc + 32'd4;
        end else begin
          m_halt  = 1'b1;
          m_fault = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk({tag, ".addr"}, imem_addr, m_pc >> 2);
    chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
    if (mq.size() > 0) begin
      chk({tag, ".pc"}, out_pc, mq[0].pc);
      chk({tag, ".instr"}, out_instr, mq[0].instr);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic redirect(input logic [31:0] target, input string tag);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick(tag);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    chk("reset.out_pc", out_pc, 32'h0);
    chk("reset.out_instr", out_instr, 32'h0);

    // Stream from reset; the 4-word instance faults at pc=16.
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick("stream");
      chk("stream.valid", {31'b0, out_valid}, 32'd1);
      chk("stream.pc", out_pc, 32'(4 * (k - 1)));
      chk("stream.instr", out_instr, 32'(8'h11 * k));
      chk("small.pc", s_pc, 32'(4 * (k - 1)));
      chk("small.fault_lo", {31'b0, s_fault}, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      tick("stream_tail");
      chk("small.fault_hi", {31'b0, s_fault}, 32'd1);
      chk("small.drained", {31'b0, s_valid}, 32'd0);
      chk("small.addr_hold", s_addr, 32'd4);
    end

    // Recovery from HALT, then a misaligned redirect.
    redirect(32'h8, "redir8");
    chk("small.fault_clr", {31'b0, s_fault}, 32'd0);
    chk("small.bubble", {31'b0, s_valid}, 32'd0);
    tick("redir8_t");
    chk("small.pc8", s_pc, 32'h8);
    chk("small.valid8", {31'b0, s_valid}, 32'd1);
    redirect(32'h6, "redir6");
    tick("redir6_t");
    chk("mis.fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis.valid", {31'b0, out_valid}, 32'd0);
    chk("small.mis_fault", {31'b0, s_fault}, 32'd1);
    tick("redir6_t2");
    chk("mis.still_empty", {31'b0, out_valid}, 32'd0);

    // Backpressure: buffer fills, pc stalls at word 2.
    out_ready = 1'b0;
    redirect(32'h0, "bp_redir");
    for (int k = 0; k < 5; k++) tick("bp");
    chk("bp.addr_freeze", imem_addr, 32'd2);
    out_ready = 1'b1;
    chk("bp.head0", out_pc, 32'h0);
    tick("bp_rel");
    chk("bp.head4", out_pc, 32'h4);

    // Redirect while popping pc=4; entry at 8 is flushed.
    redirect(32'h40, "rp");
    chk("rp.bubble", {31'b0, out_valid}, 32'd0);
    tick("rp1");
    chk("rp.pc40", out_pc, 32'h40);
    tick("rp2");
    chk("rp.pc44", out_pc, 32'h44);

    // Random traffic, including misaligned and out-of-range targets.
    for (int k = 0; k < 400; k++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = {20'h0, $urandom_range(0, 4095)} | 32'h1;
        1:       redirect_pc = 32'h0000_0FF0;
        2:       redirect_pc = 32'hFFFF_FFFC;
        default: redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      tick("rand");
    end
    redirect_valid = 1'b0;

    // Asynchronous reset with a full buffer.
    out_ready = 1'b0;
    redirect(32'h0, "ar_redir");
    tick("ar_fill1");
    tick("ar_fill2");
    chk("ar.pre_addr", imem_addr, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("ar.valid", {31'b0, out_valid}, 32'd0);
    chk("ar.addr", imem_addr, 32'd0);
    chk("ar.fault", {31'b0, fetch_fault}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    tick("ar_rel1");
    chk("ar.restart0", out_pc, 32'h0);
    tick("ar_rel2");
    chk("ar.restart4", out_pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch initiator for the single-cycle RISC-V core. Holds the program counter, drives word addresses into the combinational instruction memory, and captures returned instructions in a 2-entry buffer. The buffer feeds decode over a valid/ready handshake. Also handles control-flow redirects and halts on out-of-range or misaligned fetch addresses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; must be 4-byte aligned.
- MEM_WORDS, 1024, instruction memory depth in 32-bit words; legal word indices are 0..MEM_WORDS-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  word index to instruction memory, equal to {2'b00, pc[31:2]}; combinational from the pc register.
- imem_instr  in  32  instruction word returned combinationally by memory for imem_addr.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at buffer head.
- out_pc  out  32  byte address of out_instr.
- fetch_fault  out  1  sticky; set when fetch is halted on an illegal address.

## Operation
- State: pc (32b), 2-entry FIFO of {pc, instr}, count (0..2), state in {FETCH, HALT}.
- Pop: out_valid && out_ready.
- Fetch condition: state==FETCH and (count<2 or pop).
- On fetch: push {pc, imem_instr} and set pc <= pc+4, with 32-bit wrap.
- Legal check happens before push:
  - pc[1:0]==0 and pc[31:2] < MEM_WORDS: push normally.
  - Otherwise: no push, state <= HALT, fetch_fault <= 1, pc holds.
- HALT: no fetch. Buffered entries still drain normally. imem_addr still reflects pc.
- Redirect has highest priority:
  - A pop in the same cycle still completes; decode owns that instruction.
  - Then all FIFO entries are flushed (count <= 0), pc <= redirect_pc, state <= FETCH, fetch_fault <= 0.
  - No fetch is pushed in the redirect cycle.
- A misaligned or out-of-range redirect_pc faults on the following cycle through the normal legal check.
- Simultaneous push and pop with count==2: count stays 2, order preserved.
- out_instr/out_pc are the FIFO head registers, not combinational from imem.

## Timing
- Reset values:
  - pc=RESET_PC, count=0, state=FETCH.
  - out_valid=0, out_instr=32'h0, out_pc=32'h0, fetch_fault=0.
  - imem_addr=RESET_PC>>2.
- Reset is asynchronous. Asserting it mid-stream clears the buffer and fault immediately, with no edge needed.
- First cycle after reset release: fetch at RESET_PC. out_valid=1 one cycle later.
- Fetch-to-output latency is 1 cycle; throughput is 1 instruction/cycle with out_ready held high.
- With out_ready low, the buffer fills in 2 cycles, then pc stalls. imem_addr holds at the next unfetched word.
- Redirect at edge N:
  - out_valid=0 during cycle N+1 (target fetched).
  - Target instruction valid in cycle N+2.
  - Redirect bubble is 1 cycle.
- fetch_fault rises the cycle after the illegal pc is presented. out_valid drops once the buffer drains.

## Test plan
- Reset/stream: memory words 0..3 = 0x11,0x22,0x33,0x44, out_ready=1, release reset.
  - Required: out_valid first high 1 cycle after release.
  - Required: out_pc 0,4,8,12 with out_instr 0x11..0x44 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles, then 1.
  - Required: count saturates at 2 and imem_addr freezes at word 2.
  - Required: no instruction is lost or duplicated; out_pc continues 0,4,8 on release.
- Redirect with pop: at out_pc=4 accepted, pulse redirect_valid with redirect_pc=0x40.
  - Required: instruction at 4 consumed, entry at 8 flushed.
  - Required: out_valid=0 one cycle, then out_pc=0x40, then 0x44.
- Out-of-range: MEM_WORDS=4, stream from 0.
  - Required: pcs 0..12 delivered, then fetch_fault=1 when pc=16.
  - Required: out_valid=0 after the drain, and no further pushes.
- Fault recovery and misalignment:
  - In HALT, redirect to 0x8: fetch_fault clears and 0x8 is delivered.
  - Redirect to 0x6: fetch_fault=1 with no output.
- Async reset mid-stream: assert reset between edges with count=2.
  - Required: out_valid=0 and imem_addr=RESET_PC>>2 immediately.
  - Required: restart from RESET_PC after release.
